kid_anim_seq: RTL

//  Animation sequencer for the kid sprite. Latches action/direction once per video frame tick,

---
 rtl/kid_pkg.sv | 47 ++++
 rtl/kid_anim_seq_anim_div.sv | 31 +++
 rtl/kid_anim_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/kid_pkg.sv
// Shared kid sprite definitions: action codes, sprite geometry, divider defaults and the
// frame-offset helper used by the animation sequencer and the pixel datapath.
package kid_pkg;

  localparam logic [1:0] ACT_IDLE = 2'b00;
  localparam logic [1:0] ACT_RUN  = 2'b01;
  localparam logic [1:0] ACT_JUMP = 2'b10;
  localparam logic [1:0] ACT_FALL = 2'b11;

  localparam int KID_W      = 31;
  localparam int KID_H      = 23;
  localparam int FRAME_SIZE = KID_W * KID_H;
  localparam int NUM_FRAMES = 4;

  localparam int IDLE_DIV_DEF = 8;
  localparam int RUN_DIV_DEF  = 4;
  localparam int JUMP_DIV_DEF = 6;
  localparam int FALL_DIV_DEF = 6;

  localparam int BLINK_TICKS = 64;
  localparam int BLINK_W     = $clog2(BLINK_TICKS + 1);

  localparam int DIV_W  = 8;
  localparam int BASE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = ACT_IDLE,
    ST_RUN  = ACT_RUN,
    ST_JUMP = ACT_JUMP,
    ST_FALL = ACT_FALL
  } anim_state_t;

  // Offsets are folded to constants so no multiplier sits on the frame index path.
  function automatic logic [BASE_W-1:0] frame_offset(input logic [1:0] idx);
    logic [BASE_W-1:0] off;
    off = '0;
    case (idx)
      2'd0:    off = '0;
      2'd1:    off = BASE_W'(FRAME_SIZE);
      2'd2:    off = BASE_W'(2 * FRAME_SIZE);
      2'd3:    off = BASE_W'(3 * FRAME_SIZE);
      default: off = '0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/kid_anim_seq_anim_div.sv
// anim_div: modulo-N tick divider with synchronous clear, count enable and a terminal flag
// that is high while the count sits at modulus-1.
module anim_div
  import kid_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Terminal flag is ungated so the parent can combine it with its own enable without a loop.
  assign tc = (cnt == (modulus - W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/kid_anim_seq.sv
// kid_anim_seq: per-frame action/direction latch and 4-frame sprite-sheet sequencer.
// Optional respawn blink enabled by defining SPAWN_BLINK_EN.
module kid_anim_seq
  import kid_pkg::*;
#(
  parameter int IDLE_DIV = IDLE_DIV_DEF,
  parameter int RUN_DIV  = RUN_DIV_DEF,
  parameter int JUMP_DIV = JUMP_DIV_DEF,
  parameter int FALL_DIV = FALL_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [1:0]        action,
  input  logic              dir,
  input  logic              respawn,
  output logic [1:0]        action_q,
  output logic              dir_q,
  output logic [1:0]        frame_idx,
  output logic [BASE_W-1:0] frame_base,
  output logic              frame_strobe,
  output logic              visible
);

  anim_state_t      state_q, state_d;
  logic             dir_d;
  logic [1:0]       frame_d;
  logic             strobe_d;
  logic             div_clr, div_en, div_tc;
  logic [DIV_W-1:0] div_mod;

  assign action_q = state_q;

  always_comb begin
    div_mod = DIV_W'(IDLE_DIV);
    unique case (state_q)
      ST_IDLE: div_mod = DIV_W'(IDLE_DIV);
      ST_RUN:  div_mod = DIV_W'(RUN_DIV);
      ST_JUMP: div_mod = DIV_W'(JUMP_DIV);
      ST_FALL: div_mod = DIV_W'(FALL_DIV);
    endcase
  end

  anim_div #(.W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .en      (div_en),
    .modulus (div_mod),
    .tc      (div_tc)
  );

  // Respawn overrides the tick except for the direction latch.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    frame_d  = frame_idx;
    div_clr  = 1'b0;
    div_en   = 1'b0;
    strobe_d = 1'b0;
    if (respawn) begin
      state_d  = ST_IDLE;
      frame_d  = '0;
      div_clr  = 1'b1;
      strobe_d = 1'b1;
      if (tick) begin
        dir_d = dir;
      end
    end else if (tick) begin
      dir_d = dir;
      if (action != state_q) begin
        state_d = anim_state_t'(action);
        frame_d = '0;
        div_clr = 1'b1;
      end else begin
        div_en = 1'b1;
        if (div_tc) begin
          frame_d = frame_idx + 2'd1;
        end
      end
      strobe_d = (state_d != state_q) || (dir_d != dir_q) || (frame_d != frame_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= 1'b1;
      frame_idx    <= '0;
      frame_base   <= '0;
      frame_strobe <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      frame_idx    <= frame_d;
      frame_base   <= frame_offset(frame_d);
      frame_strobe <= strobe_d;
    end
  end

`ifdef SPAWN_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;

  // Bit 2 of the countdown gives a 4-tick on/off flash until the counter drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else if (respawn) begin
      blink_cnt <= BLINK_W'(BLINK_TICKS);
    end else if (tick && (blink_cnt != '0)) begin
      blink_cnt <= blink_cnt - BLINK_W'(1);
    end
  end

  assign visible = (blink_cnt == '0) | ~blink_cnt[2];
`else
  assign visible = 1'b1;
`endif

endmodule
